// File: rtl/la_capture_mux_pkg.sv
// Shared types for the logic-analyser capture mux.
//   la_mode_e    : decoded value of the 2-bit mode input
//   la_state_e   : capture FSM state encoding
//   LA_DEFAULT_W : default probe bus width
package la_pkg;

   localparam int unsigned LA_DEFAULT_W = 32;

   typedef enum logic [1:0] {
      LA_LIVE = 2'd0,
      LA_HOLD = 2'd1,
      LA_TRIG = 2'd2,
      LA_RSVD = 2'd3
   } la_mode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LIVE  = 3'd1,
      HOLD  = 3'd2,
      ARMED = 3'd3,
      CAPT  = 3'd4
   } la_state_e;

endpackage

// File: rtl/la_capture_mux_if.sv
// Bundle of the capture mux control, probe and result signals.
//   slave  : view taken by la_capture_mux
//   master : view taken by whatever drives the mux (SoC glue or a bench)
interface la_capture_mux_if
   import la_pkg::*;
#(
   parameter int unsigned NUM_TEAMS = 12,
   parameter int unsigned DATA_W    = LA_DEFAULT_W,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned DIV_W     = 8
) ();

   logic [SEL_W-1:0]                  la_sel;
   logic [DATA_W*(NUM_TEAMS+1)-1:0]   designs_la_data_out_flat;
   logic [1:0]                        mode;
   logic [DIV_W-1:0]                  clk_div;
   logic                              arm;
   logic [DATA_W-1:0]                 trig_value;
   logic [DATA_W-1:0]                 trig_mask;
   logic [DATA_W-1:0]                 muxxed_la_dat;
   logic                              armed;
   logic                              triggered;

   modport slave (
      input  la_sel, designs_la_data_out_flat, mode, clk_div, arm, trig_value, trig_mask,
      output muxxed_la_dat, armed, triggered
   );

   modport master (
      output la_sel, designs_la_data_out_flat, mode, clk_div, arm, trig_value, trig_mask,
      input  muxxed_la_dat, armed, triggered
   );

endinterface

// File: rtl/la_capture_mux_tick_div.sv
// Sample-rate divider: tick is high one cycle in every clk_div+1.
//   clk     : system clock
//   nrst    : asynchronous active-low reset
//   clk_div : divide value minus one (0 = tick every cycle)
//   tick    : sample strobe
module la_tick_div #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [DIV_W-1:0] clk_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // >= rather than == so a clk_div lowered below the running count wraps
   // immediately instead of running the counter round through overflow.
   always_comb begin
      tick  = (cnt_q >= clk_div);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/la_capture_mux.sv
// Logic-analyser capture mux: selects one of NUM_TEAMS+1 probe buses, samples
// it on divider ticks and drives the shared LA output. Supports live, hold and
// masked-compare trigger capture, and blanks the output for one cycle when the
// source select changes.
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   la_if : slave view of la_capture_mux_if (select, probes, mode, divider,
//           trigger controls in; muxxed_la_dat, armed, triggered out)
module la_capture_mux
   import la_pkg::*;
#(
   parameter int unsigned NUM_TEAMS = 12,
   parameter int unsigned DATA_W    = LA_DEFAULT_W,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned DIV_W     = 8
) (
   input  logic              clk,
   input  logic              nrst,
   la_capture_mux_if.slave   la_if
);

   localparam int unsigned NumSlots = 2 ** SEL_W;

   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] out_q, out_d;
   la_state_e         state_q, state_d;
   logic              tick;
   la_mode_e          mode_e;
   logic [DATA_W-1:0] src;
   logic              mode_change;
   la_state_e         mode_state;

   // Select slots beyond the last real source read as zero.
   logic [DATA_W-1:0] srcs [NumSlots];

   for (genvar gi = 0; gi < NumSlots; gi++) begin : g_src
      if (gi <= NUM_TEAMS) begin : g_valid
         assign srcs[gi] = la_if.designs_la_data_out_flat[gi*DATA_W +: DATA_W];
      end else begin : g_zero
         assign srcs[gi] = '0;
      end
   end

   assign src    = srcs[sel_q];
   assign mode_e = la_mode_e'(la_if.mode);

   la_tick_div #(
      .DIV_W (DIV_W)
   ) u_tick_div (
      .clk     (clk),
      .nrst    (nrst),
      .clk_div (la_if.clk_div),
      .tick    (tick)
   );

   // A mode change is any mismatch between the requested mode and the state
   // family we are in; IDLE/ARMED/CAPT all belong to TRIG.
   always_comb begin
      mode_change = 1'b0;
      mode_state  = state_q;
      unique case (mode_e)
         LA_LIVE: begin
            mode_change = (state_q != LIVE);
            mode_state  = LIVE;
         end
         LA_TRIG: begin
            mode_change = (state_q == LIVE) || (state_q == HOLD);
            mode_state  = IDLE;
         end
         default: begin
            mode_change = (state_q != HOLD);
            mode_state  = HOLD;
         end
      endcase
   end

   always_comb begin
      sel_d   = sel_q;
      out_d   = out_q;
      state_d = state_q;
      if (la_if.la_sel != sel_q) begin
         sel_d = la_if.la_sel;
         out_d = '0;
         // Any pending or held capture is abandoned on a source switch.
         if (mode_e == LA_TRIG || state_q == ARMED || state_q == CAPT) begin
            state_d = IDLE;
         end
      end else if (mode_change) begin
         state_d = mode_state;
      end else begin
         unique case (state_q)
            LIVE: begin
               if (tick) out_d = src;
            end
            HOLD: begin
               out_d = out_q;
            end
            IDLE: begin
               if (la_if.arm) state_d = ARMED;
            end
            ARMED: begin
               if (tick) begin
                  out_d = src;
                  if (((src ^ la_if.trig_value) & la_if.trig_mask) == '0) state_d = CAPT;
               end
            end
            CAPT: begin
               if (la_if.arm) state_d = ARMED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sel_q   <= '0;
         out_q   <= '0;
         state_q <= IDLE;
      end else begin
         sel_q   <= sel_d;
         out_q   <= out_d;
         state_q <= state_d;
      end
   end

   assign la_if.muxxed_la_dat = out_q;
   assign la_if.armed         = (state_q == ARMED);
   assign la_if.triggered     = (state_q == CAPT);

endmodule

// File: tb/tb_la_capture_mux.sv
// Directed self-checking bench for la_capture_mux.
module tb_la_capture_mux;
   import la_pkg::*;

   localparam int unsigned NT = 12;
   localparam int unsigned DW = 32;

   logic clk;
   logic nrst;
   logic [DW-1:0] srcs [NT+1];
   logic [DW*(NT+1)-1:0] flat;

   int n_total = 0;
   int n_bad   = 0;

   la_capture_mux_if #(.NUM_TEAMS(NT), .DATA_W(DW), .SEL_W(4), .DIV_W(8)) la_if ();

   la_capture_mux #(.NUM_TEAMS(NT), .DATA_W(DW), .SEL_W(4), .DIV_W(8)) u_dut (
      .clk   (clk),
      .nrst  (nrst),
      .la_if (la_if)
   );

   always_comb begin
      flat = '0;
      for (int i = 0; i <= int'(NT); i++) flat[i*DW +: DW] = srcs[i];
   end
   assign la_if.designs_la_data_out_flat = flat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_out;
   logic        hit;

   initial begin
      nrst = 1'b0;
      la_if.la_sel     = '0;
      la_if.mode       = 2'd0;
      la_if.clk_div    = '0;
      la_if.arm        = 1'b0;
      la_if.trig_value = '0;
      la_if.trig_mask  = '0;
      for (int i = 0; i <= int'(NT); i++) srcs[i] = 32'hA000_0000 + i;
      step();
      step();
      check("rst_out", la_if.muxxed_la_dat, 32'h0);
      check("rst_armed", {31'b0, la_if.armed}, 32'h0);
      check("rst_trig", {31'b0, la_if.triggered}, 32'h0);
      nrst = 1'b1;

      // LIVE, divide by 1
      step();
      check("live_enter", la_if.muxxed_la_dat, 32'h0);
      step();
      check("live_src0", la_if.muxxed_la_dat, 32'hA000_0000);
      la_if.la_sel = 4'd3;
      step();
      check("blank_3", la_if.muxxed_la_dat, 32'h0);
      step();
      check("live_src3", la_if.muxxed_la_dat, 32'hA000_0003);
      step();
      check("live_src3_b", la_if.muxxed_la_dat, 32'hA000_0003);
      la_if.la_sel = 4'd13;
      step();
      check("blank_13", la_if.muxxed_la_dat, 32'h0);
      step();
      check("oor_13", la_if.muxxed_la_dat, 32'h0);
      la_if.la_sel = 4'd12;
      step();
      check("blank_12", la_if.muxxed_la_dat, 32'h0);
      step();
      check("live_src12", la_if.muxxed_la_dat, 32'hA000_000C);

      // divide by 4 with an incrementing source
      la_if.la_sel = 4'd5;
      step();
      check("blank_5", la_if.muxxed_la_dat, 32'h0);
      step();
      check("live_src5", la_if.muxxed_la_dat, 32'hA000_0005);
      la_if.clk_div = 8'd3;
      exp_out = 32'hA000_0005;
      for (int k = 0; k < 12; k++) begin
         srcs[5] = 32'h5000_0000 + k;
         if (k % 4 == 3) exp_out = 32'h5000_0000 + k;
         step();
         check("div4", la_if.muxxed_la_dat, exp_out);
      end
      la_if.clk_div = 8'd0;

      // HOLD
      la_if.mode = 2'd1;
      for (int k = 0; k < 20; k++) begin
         srcs[5] = 32'h6000_0000 + k;
         step();
         check("hold_out", la_if.muxxed_la_dat, 32'h5000_000B);
      end
      check("hold_armed", {31'b0, la_if.armed}, 32'h0);
      check("hold_trig", {31'b0, la_if.triggered}, 32'h0);

      // TRIG with masked compare
      la_if.mode       = 2'd2;
      la_if.trig_mask  = 32'h0000_FFFF;
      la_if.trig_value = 32'h0000_1234;
      srcs[5] = 32'hABCD_1230;
      step();
      check("trig_idle_armed", {31'b0, la_if.armed}, 32'h0);
      check("trig_idle_out", la_if.muxxed_la_dat, 32'h5000_000B);
      la_if.arm = 1'b1;
      step();
      la_if.arm = 1'b0;
      check("arm_armed", {31'b0, la_if.armed}, 32'h1);
      check("arm_out", la_if.muxxed_la_dat, 32'h5000_000B);
      hit = 1'b0;
      exp_out = 32'h5000_000B;
      for (int v = 32'h1230; v <= 32'h1240; v++) begin
         srcs[5] = 32'hABCD_0000 | v;
         if (!hit) begin
            exp_out = 32'hABCD_0000 | v;
            if (v == 32'h1234) hit = 1'b1;
         end
         step();
         check("ramp_out", la_if.muxxed_la_dat, exp_out);
         check("ramp_trig", {31'b0, la_if.triggered}, {31'b0, hit});
         check("ramp_armed", {31'b0, la_if.armed}, {31'b0, !hit});
      end

      // re-arm from CAPT with mask 0
      la_if.trig_mask = 32'h0;
      srcs[5] = 32'h7777_0001;
      la_if.arm = 1'b1;
      step();
      la_if.arm = 1'b0;
      check("rearm_trig", {31'b0, la_if.triggered}, 32'h0);
      check("rearm_armed", {31'b0, la_if.armed}, 32'h1);
      check("rearm_out", la_if.muxxed_la_dat, 32'hABCD_1234);
      srcs[5] = 32'h7777_0002;
      step();
      check("m0_trig", {31'b0, la_if.triggered}, 32'h1);
      check("m0_out", la_if.muxxed_la_dat, 32'h7777_0002);
      srcs[5] = 32'h7777_0003;
      step();
      check("m0_held", la_if.muxxed_la_dat, 32'h7777_0002);

      // select change while ARMED
      la_if.trig_mask  = 32'hFFFF_FFFF;
      la_if.trig_value = 32'h0;
      srcs[5] = 32'h0000_1111;
      la_if.arm = 1'b1;
      step();
      la_if.arm = 1'b0;
      check("sa_armed", {31'b0, la_if.armed}, 32'h1);
      step();
      check("sa_sample", la_if.muxxed_la_dat, 32'h0000_1111);
      la_if.la_sel = 4'd6;
      step();
      check("sa_blank", la_if.muxxed_la_dat, 32'h0);
      check("sa_disarm", {31'b0, la_if.armed}, 32'h0);
      step();
      check("sa_idle_out", la_if.muxxed_la_dat, 32'h0);

      // arm coinciding with a mode change is dropped
      la_if.mode = 2'd0;
      step();
      la_if.mode = 2'd2;
      la_if.arm  = 1'b1;
      step();
      la_if.arm = 1'b0;
      step();
      check("arm_drop", {31'b0, la_if.armed}, 32'h0);

      // capture then async reset
      la_if.trig_mask = 32'h0;
      la_if.arm = 1'b1;
      step();
      la_if.arm = 1'b0;
      step();
      check("cap6_trig", {31'b0, la_if.triggered}, 32'h1);
      check("cap6_out", la_if.muxxed_la_dat, 32'hA000_0006);
      #2;
      nrst = 1'b0;
      #1;
      check("arst_out", la_if.muxxed_la_dat, 32'h0);
      check("arst_armed", {31'b0, la_if.armed}, 32'h0);
      check("arst_trig", {31'b0, la_if.triggered}, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/la_capture_mux.md
Name: la_capture_mux

Overview:
- Parametrised successor to the logic-analyser select mux.
- Selects one of NUM_TEAMS+1 packed DATA_W-bit probe buses, registers the result, and drives the shared LA output.
- Adds:
  - a sample-rate divider,
  - a freeze (hold) mode,
  - a masked-compare trigger that captures and holds one sample,
  - out-of-range select zeroing,
  - one blanking cycle on select change.

Parameters:
- NUM_TEAMS, 12, number of team designs; total sources = NUM_TEAMS+1 (index 0 = management/default).
- DATA_W, 32, width of each probe bus and of the output.
- SEL_W, 4, la_sel width; must satisfy 2**SEL_W >= NUM_TEAMS+1.
- DIV_W, 8, width of the sample divider.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- la_sel  input  SEL_W  source select
- designs_la_data_out_flat  input  DATA_W*(NUM_TEAMS+1)  packed sources; source i at [i*DATA_W +: DATA_W]
- mode  input  2  0 = LIVE, 1 = HOLD, 2 = TRIG, 3 = reserved (treated as HOLD)
- clk_div  input  DIV_W  sample tick every clk_div+1 cycles
- arm  input  1  single-cycle pulse; arms the trigger in TRIG mode
- trig_value  input  DATA_W  compare value
- trig_mask  input  DATA_W  1 = bit participates in the compare
- muxxed_la_dat  output  DATA_W  registered selected/captured data
- armed  output  1  trigger waiting
- triggered  output  1  capture held

Behaviour:
- Reset (async, nrst=0): muxxed_la_dat=0, armed=0, triggered=0, div counter=0, sel_q=0, state=IDLE.
- Select:
  - sel_q is the registered la_sel.
  - src = data[sel_q] if sel_q <= NUM_TEAMS, else all zeros.
- Divider:
  - Counter cnt increments each cycle.
  - When cnt >= clk_div: tick=1 and cnt returns to 0.
  - clk_div=0 gives a tick every cycle.
  - A change of clk_div takes effect at the next wrap; no counter overflow is possible.
- Select change: if la_sel != sel_q in cycle N:
  - sel_q <= la_sel;
  - muxxed_la_dat <= 0 (blank) in N+1;
  - armed <= 0, triggered <= 0, state <= IDLE (TRIG) or unchanged (LIVE/HOLD).
  - Takes priority over every other update in that cycle.
- Latency: a sample taken on a tick in cycle N is visible on muxxed_la_dat in cycle N+1. Output changes only on ticks, blanking, or reset.
- FSM states: IDLE, LIVE, HOLD, ARMED, CAPT. Transitions are evaluated every cycle, in this priority order:
  1. select change, as above.
  2. mode change:
     - LIVE -> state LIVE.
     - HOLD/reserved -> state HOLD (output frozen at its current value).
     - TRIG -> state IDLE (output frozen); armed and triggered cleared.
  3. LIVE: on tick, out <= src.
  4. HOLD: no update.
  5. IDLE (TRIG mode): on arm -> ARMED, armed=1; output frozen.
  6. ARMED:
     - on tick, out <= src.
     - if ((src ^ trig_value) & trig_mask) == 0 on the same tick -> CAPT, armed=0, triggered=1, and out holds that matching sample.
     - trig_mask = 0 triggers on the first tick after arming.
  7. CAPT: out held. arm -> ARMED (triggered=0, armed=1); no sample is taken in that cycle.
- arm in ARMED is ignored; arm outside TRIG mode is ignored.
- arm is sampled on any cycle, not only on ticks. A trigger compare happens only on ticks.
- Simultaneous arm and mode change: the mode change wins and arm is dropped.

Decomposition:
- Package la_pkg holds:
  - typedef la_mode_e (LA_LIVE, LA_HOLD, LA_TRIG, LA_RSVD);
  - typedef la_state_e (IDLE, LIVE, HOLD, ARMED, CAPT);
  - localparam LA_DEFAULT_W = 32.
- One sub-module: la_tick_div (DIV_W counter; inputs clk, nrst, clk_div; output tick).

Test Plan:
- Reset, then mode=LIVE, clk_div=0, source i = 32'hA000_0000+i, la_sel=3 -> after 1 blank cycle, out=32'hA000_0003 one cycle after each tick. la_sel=13 -> 0.
- clk_div=3, LIVE, source 5 incrementing every cycle -> out updates every 4th cycle, each value lagging its sample cycle by 1.
- mode LIVE->HOLD while source changes -> out stays at its last value for 20 cycles; armed=triggered=0.
- TRIG: trig_mask=32'h0000_FFFF, trig_value=32'h0000_1234, arm pulse, source ramps 0x1230..0x1240 -> triggered=1 and out=0x1234 held; later samples are ignored.
- CAPT then arm again with mask=0 -> triggered drops, next tick recaptures the current source, triggered=1.
- Edge cases:
  - la_sel change while ARMED -> out=0 next cycle and armed=0.
  - nrst asserted mid-CAPT -> all outputs 0 asynchronously.
